// File: rtl/output_drain_ctrl_pkg.sv
// Shared types and constants for the output drain sequencer.
// Holds the FSM state encoding, the default widths and the rounding-constant helper.
package drain_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } drain_state_e;

    localparam int DEF_LANES             = 8;
    localparam int DEF_ACC_WIDTH         = 32;
    localparam int DEF_OUT_WIDTH         = 8;
    localparam int DEF_C_ADDR_WIDTH      = 10;
    localparam int DEF_D_ADDR_WIDTH      = 9;
    localparam int DEF_BRAM_READ_LATENCY = 1;

    // Half an LSB of the shifted result, so the arithmetic shift rounds half-up.
    function automatic logic [DEF_ACC_WIDTH:0] round_const(input logic [4:0] shift);
        if (shift == 5'd0) begin
            return '0;
        end
        return (DEF_ACC_WIDTH + 1)'(1) << (shift - 5'd1);
    endfunction

endpackage

// File: rtl/output_drain_ctrl_if.sv
// Command, C-read, D-write and status signals of the drain sequencer.
// Handshake: a command transfers on a rising edge where cmd_valid and cmd_ready are both high.
interface output_drain_ctrl_if #(
    parameter int LANES        = drain_pkg::DEF_LANES,
    parameter int ACC_WIDTH    = drain_pkg::DEF_ACC_WIDTH,
    parameter int OUT_WIDTH    = drain_pkg::DEF_OUT_WIDTH,
    parameter int C_ADDR_WIDTH = drain_pkg::DEF_C_ADDR_WIDTH,
    parameter int D_ADDR_WIDTH = drain_pkg::DEF_D_ADDR_WIDTH
);
    logic                          cmd_valid;
    logic                          cmd_ready;
    logic [C_ADDR_WIDTH-1:0]       cmd_src;
    logic [D_ADDR_WIDTH-1:0]       cmd_dst;
    logic [C_ADDR_WIDTH-1:0]       cmd_len;
    logic [4:0]                    cmd_shift;
    logic                          cmd_relu;
    logic [C_ADDR_WIDTH-1:0]       c_addr;
    logic                          c_en;
    logic [LANES*ACC_WIDTH-1:0]    c_dout;
    logic [D_ADDR_WIDTH-1:0]       d_addr;
    logic [LANES*OUT_WIDTH-1:0]    d_din;
    logic                          d_we;
    logic                          busy;
    logic                          done;
    logic [1:0]                    dbg_state;

    modport master (
        input  cmd_valid, cmd_src, cmd_dst, cmd_len, cmd_shift, cmd_relu, c_dout,
        output cmd_ready, c_addr, c_en, d_addr, d_din, d_we, busy, done, dbg_state
    );

    modport slave (
        output cmd_valid, cmd_src, cmd_dst, cmd_len, cmd_shift, cmd_relu, c_dout,
        input  cmd_ready, c_addr, c_en, d_addr, d_din, d_we, busy, done, dbg_state
    );
endinterface

// File: rtl/output_drain_ctrl_requant_lane.sv
// One accumulator lane: round-half-up shift, optional ReLU, saturate to OUT_WIDTH.
// Purely combinational; the parent registers the packed result.
module requant_lane
    import drain_pkg::*;
#(
    parameter int ACC_WIDTH = DEF_ACC_WIDTH,
    parameter int OUT_WIDTH = DEF_OUT_WIDTH
) (
    input  logic [ACC_WIDTH-1:0] acc,
    input  logic [4:0]           shift,
    input  logic                 relu,
    output logic [OUT_WIDTH-1:0] q
);
    localparam logic signed [ACC_WIDTH:0] SAT_MAX = (ACC_WIDTH + 1)'((1 << (OUT_WIDTH - 1)) - 1);
    localparam logic signed [ACC_WIDTH:0] SAT_MIN = ~SAT_MAX;

    logic signed [ACC_WIDTH:0] v;
    logic signed [ACC_WIDTH:0] r;

    // One extra bit keeps the rounding add from wrapping near the positive limit.
    always_comb begin
        v = $signed({acc[ACC_WIDTH-1], acc}) + $signed((ACC_WIDTH + 1)'(round_const(shift)));
        r = v >>> shift;
        if (relu && r[ACC_WIDTH]) begin
            r = '0;
        end
        if (r > SAT_MAX) begin
            r = SAT_MAX;
        end else if (r < SAT_MIN) begin
            r = SAT_MIN;
        end
        q = r[OUT_WIDTH-1:0];
    end
endmodule

// File: rtl/output_drain_ctrl.sv
// Drains accumulator rows from the C buffer into packed int8 words in the D buffer,
// one row per cycle, with per-lane requantization and a registered write stage.
module output_drain_ctrl
    import drain_pkg::*;
#(
    parameter int LANES             = DEF_LANES,
    parameter int ACC_WIDTH         = DEF_ACC_WIDTH,
    parameter int OUT_WIDTH         = DEF_OUT_WIDTH,
    parameter int C_ADDR_WIDTH      = DEF_C_ADDR_WIDTH,
    parameter int D_ADDR_WIDTH      = DEF_D_ADDR_WIDTH,
    parameter int BRAM_READ_LATENCY = DEF_BRAM_READ_LATENCY
) (
    input logic               clk,
    input logic               rst,
    output_drain_ctrl_if.master bus
);
    localparam int L = BRAM_READ_LATENCY;

    localparam logic [1:0] IDLE  = ST_IDLE;
    localparam logic [1:0] READ  = ST_READ;
    localparam logic [1:0] DRAIN = ST_DRAIN;
    localparam logic [1:0] DONE  = ST_DONE;

    logic [1:0]                 state;
    logic [C_ADDR_WIDTH-1:0]    src_ptr;
    logic [C_ADDR_WIDTH-1:0]    rem;
    logic [D_ADDR_WIDTH-1:0]    dst_ptr;
    logic [D_ADDR_WIDTH-1:0]    d_addr_q;
    logic [4:0]                 shift_q;
    logic                       relu_q;
    logic [L-1:0]               vpipe;
    logic                       d_we_q;
    logic [LANES*OUT_WIDTH-1:0] d_din_q;
    logic [LANES*OUT_WIDTH-1:0] q_word;
    logic                       rd_en;

    assign rd_en = (state == READ);

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        requant_lane #(
            .ACC_WIDTH(ACC_WIDTH),
            .OUT_WIDTH(OUT_WIDTH)
        ) u_lane (
            .acc  (bus.c_dout[k*ACC_WIDTH +: ACC_WIDTH]),
            .shift(shift_q),
            .relu (relu_q),
            .q    (q_word[k*OUT_WIDTH +: OUT_WIDTH])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            src_ptr  <= '0;
            rem      <= '0;
            dst_ptr  <= '0;
            d_addr_q <= '0;
            shift_q  <= '0;
            relu_q   <= 1'b0;
            vpipe    <= '0;
            d_we_q   <= 1'b0;
            d_din_q  <= '0;
        end else begin
            vpipe[0] <= rd_en;
            for (int i = 1; i < L; i++) begin
                vpipe[i] <= vpipe[i-1];
            end
            d_we_q <= vpipe[L-1];
            if (vpipe[L-1]) begin
                d_addr_q <= dst_ptr;
                dst_ptr  <= dst_ptr + 1'b1;
                d_din_q  <= q_word;
            end
            case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        src_ptr <= bus.cmd_src;
                        dst_ptr <= bus.cmd_dst;
                        rem     <= bus.cmd_len;
                        shift_q <= bus.cmd_shift;
                        relu_q  <= bus.cmd_relu;
                        state   <= (bus.cmd_len == '0) ? DONE : READ;
                    end
                end
                READ: begin
                    src_ptr <= src_ptr + 1'b1;
                    rem     <= rem - 1'b1;
                    if (rem == C_ADDR_WIDTH'(1)) begin
                        state <= DRAIN;
                    end
                end
                // Once the pipe is empty the last row is already in the write register,
                // so its write lands in the same cycle this transition is taken.
                DRAIN: begin
                    if (vpipe == '0) begin
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.cmd_ready = (state == IDLE);
    assign bus.c_en      = rd_en;
    assign bus.c_addr    = src_ptr;
    assign bus.d_addr    = d_addr_q;
    assign bus.d_din     = d_din_q;
    assign bus.d_we      = d_we_q;
    assign bus.busy      = (state != IDLE);
    assign bus.done      = (state == DONE);
    assign bus.dbg_state = state;
endmodule

// File: doc/output_drain_ctrl.md
# output_drain_ctrl

Sequencer that drains finished accumulator rows from the output buffer (C-side BRAM, 8 lanes × 32 bit per word) into the 64-bit D-side BRAM as packed int8 results. It sits beside `matrix_mul_ctrl` in `accelerator_top`. It accepts one drain command at a time from the main controller, streams reads at one row per cycle, and requantizes each lane with a rounding shift, optional ReLU and saturation. It then writes one packed 64-bit word per row.

## Interface
- `LANES`, 8, lanes per C word / bytes per D word
- `ACC_WIDTH`, 32, accumulator lane width in C
- `OUT_WIDTH`, 8, packed result lane width in D
- `C_ADDR_WIDTH`, 10, C BRAM address width
- `D_ADDR_WIDTH`, 9, D BRAM address width
- `BRAM_READ_LATENCY`, 1, C read latency in cycles (≥1)

Ports:
- `clk`  in  1  sole clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `cmd_valid`  in  1  drain command offered
- `cmd_ready`  out  1  high only in IDLE
- `cmd_src`  in  C_ADDR_WIDTH  first C row
- `cmd_dst`  in  D_ADDR_WIDTH  first D word
- `cmd_len`  in  C_ADDR_WIDTH  row count; 0 is legal
- `cmd_shift`  in  5  right-shift amount 0..31
- `cmd_relu`  in  1  clamp negatives to 0
- `c_addr`  out  C_ADDR_WIDTH  C read address
- `c_en`  out  1  C read enable
- `c_dout`  in  LANES*ACC_WIDTH  C read data
- `d_addr`  out  D_ADDR_WIDTH  D write address
- `d_din`  out  LANES*OUT_WIDTH  D write data
- `d_we`  out  1  D write strobe
- `busy`  out  1  not IDLE
- `done`  out  1  one-cycle completion pulse

## Operation
- States:
  - IDLE: `cmd_ready`=1. A handshake latches src, dst, len, shift and relu; the block then goes to DONE if len==0, otherwise to READ.
  - READ: one read issued per cycle at src+i for i=0..len-1. After the last issue → DRAIN.
  - DRAIN: waits until the valid pipeline and write stage are empty → DONE.
  - DONE: `done`=1 for one cycle → IDLE.
- Read valid is carried through a shift pipe of depth BRAM_READ_LATENCY. Returning data is requantized and registered, then written to dst+i.
- Per lane k (`c_dout[32k+31:32k]`, signed):
  - Compute in ACC_WIDTH+1 bits: v = x + (shift>0 ? 1<<(shift-1) : 0).
  - r = v >>> shift.
  - If relu and r<0, then r=0.
  - Saturate r to [-128,127].
  - Place the result at `d_din[8k+7:8k]`.
- Source and destination address increments wrap modulo 2^C_ADDR_WIDTH and 2^D_ADDR_WIDTH; no error is raised.
- `cmd_valid` outside IDLE is ignored. A command offered during the DONE cycle is accepted in the following IDLE cycle.
- `rst` mid-operation returns the block to IDLE, drops all in-flight data, and suppresses both writes and `done`.

## Timing
- Reset values: `cmd_ready`=1; `c_en`, `d_we`, `busy`, `done`=0; `c_addr`, `d_addr`, `d_din`=0.
- Handshake at cycle T: `c_addr`=src+i and `c_en`=1 at T+1+i.
- Data for row i arrives at T+1+i+L, where L=BRAM_READ_LATENCY.
- `d_we`=1 with `d_addr`=dst+i at T+2+i+L.
- Writes are back-to-back, len cycles, with no bubbles.
- `done` is asserted at T+3+(len-1)+L, i.e. T+len+L+2. For len==0, `done` is asserted at T+1.
- `busy` is high from T+1 through the `done` cycle.
- Throughput: one row per cycle. No back-pressure on D; the block owns the D write port while `busy`.

## Structure
- Package `drain_pkg`:
  - state enum {IDLE, READ, DRAIN, DONE}
  - default width constants
  - rounding constant helper
- Sub-module `requant_lane`: one lane of round, shift, ReLU and saturate, purely combinational. It is instantiated LANES times via generate; its output register lives in the parent.
- The parent holds the FSM, the counters, the valid shift pipe and the write-stage registers.

## Test plan
- src=0x010, dst=0x020, len=3, shift=0, relu=0; lane0 values 5, -3, 200. Expected: writes at 0x020..0x022 with lane0 bytes 0x05, 0xFD, 0x7F; `done` at T+6 for L=1.
- shift=4, lane values 24, 23, -24, -25. Expected bytes 2, 1, -1, -2 (0x02, 0x01, 0xFF, 0xFE), confirming round-half-up.
- relu=1, shift=0, lanes -100, 0x7FFFFFFF, 0x80000000, 77. Expected bytes 0x00, 0x7F, 0x00, 0x4D, with no overflow in the rounding adder.
- len=0 → `done` at T+1 and no `c_en`/`d_we`. Then src=0x3FE, dst=0x1FF, len=4 → reads 0x3FE, 0x3FF, 0x000, 0x001 and writes 0x1FF, 0x000, 0x001, 0x002.
- `cmd_valid` held high throughout len=5 → exactly one accept per IDLE, and the second command starts the cycle after `done`.
- `rst` asserted in the cycle of the 2nd write of a len=8 drain → next cycle all outputs at reset values, no further `d_we`, no `done`, `cmd_ready`=1.
